hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It keeps its own shadow copy of destination-register state for EX, MEM and WB. From that state it drives:
- stall and flush controls for the pipeline registers;
- operand forwarding selects for the EX-stage ALU;
- saturating performance counters for load-use stalls and redirect flushes.

It sits beside the decoder and immediate generator in ID and consumes decoded register fields only.

Parameters:
REG_AW, 5, register index width
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  ID holds a real instruction
id_rs1_i  in  REG_AW  ID source 1 index
id_rs2_i  in  REG_AW  ID source 2 index
id_rs1_used_i  in  1  instruction reads rs1
id_rs2_used_i  in  1  instruction reads rs2
id_rd_i  in  REG_AW  ID destination index
id_rd_wren_i  in  1  instruction writes rd
id_is_load_i  in  1  instruction is a load (IL opcode)
ex_redirect_i  in  1  EX resolved taken branch or jump
mem_stall_i  in  1  LSU busy; freeze whole pipeline
stall_if_o  out  1  hold PC / IF-ID register
stall_id_o  out  1  hold ID
stall_ex_o  out  1  hold ID-EX and EX-MEM registers
stall_mem_o  out  1  hold MEM-WB register
flush_id_o  out  1  clear IF-ID register to bubble
flush_ex_o  out  1  load bubble into ID-EX register
fwd_a_sel_o  out  2  EX operand A: 00 regfile, 01 MEM ALU result, 10 WB data
fwd_b_sel_o  out  2  EX operand B: same encoding
loaduse_cnt_o  out  CNT_W  load-use stall cycles
flush_cnt_o  out  CNT_W  redirect flush events

Behaviour:
Interface:
- One clock; reset is synchronous and active-high (clk_i, rst_i).

Shadow state:
- Each entry of ex_q, mem_q, wb_q holds {valid, rd, wren, is_load}.
- ex_q additionally holds {rs1, rs1_used, rs2, rs2_used}.

Reset:
- All shadow valid=0.
- Counters 0.
- All outputs are combinational from state and inputs; with valid=0 and inputs idle they evaluate to 0 and fwd=00.

Priority, highest first: mem_stall_i, then ex_redirect_i, then load-use.

Freeze (mem_stall_i=1):
- stall_if/id/ex/mem = 1, flush_* = 0.
- Shadow registers and counters hold.
- A redirect present during the freeze is acted on in the first cycle after mem_stall_i drops.

Redirect (ex_redirect_i=1, no freeze):
- flush_id=1, flush_ex=1, no stalls.
- Next cycle: ex_q = bubble (valid=0); mem_q <= ex_q; wb_q <= mem_q.
- flush_cnt +1 (saturating).
- Load-use on the same cycle is suppressed, and loaduse_cnt does not increment.

Load-use (no freeze, no redirect):
- Condition: id_valid_i & ex_q.valid & ex_q.is_load & ex_q.rd!=0 & ((id_rs1_used_i & id_rs1_i==ex_q.rd) | (id_rs2_used_i & id_rs2_i==ex_q.rd)).
- Response: stall_if=1, stall_id=1, flush_ex=1.
- Next cycle: ex_q = bubble, mem_q/wb_q advance.
- loaduse_cnt +1 (saturating). Exactly one bubble is inserted per hazard.

Normal:
- ex_q <= ID fields, with valid = id_valid_i; mem_q <= ex_q; wb_q <= mem_q.

Forwarding (combinational, EX operands), per operand:
- If ex_q.valid & used & rs!=0 & mem_q.valid & mem_q.wren & mem_q.rd==rs, then 01.
- Else if the same check against wb_q matches, then 10.
- Else 00.
- MEM has priority over WB for the same rd.
- x0 is never forwarded.
- A MEM-stage load matching EX cannot occur, because load-use guarantees it. An SVA assertion flags it.

Counters:
- Saturate at all-ones.
- Reset clears them; there is no other clear.

Reset mid-operation:
- rst_i wins over every input.
- All shadow valid=0 the following cycle, regardless of stall or flush.

Decomposition:
- Shared core package: stage_info_t struct {valid, rd, wren, is_load} and FWD_REG/FWD_MEM/FWD_WB constants for the 2-bit selects.
- Sub-module fwd_sel: one instance per operand, purely combinational. Its inputs are rs, used, mem_q and wb_q; its output is sel.

Test Plan:
1. lw x5 in EX, add x6,x5,x1 in ID -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle. Next cycle with add in EX: fwd_a_sel=10. loaduse_cnt=1.
2. add x3 in MEM, sub x7,x3,x3 in EX -> fwd_a_sel=01, fwd_b_sel=01. Same rd also in WB -> still 01.
3. add x0 writes, consumer reads x0 -> fwd sel=00, no stall.
4. ex_redirect_i with load-use condition also true -> flush_id=flush_ex=1, stall_if=0. flush_cnt +1, loaduse_cnt unchanged.
5. mem_stall_i held 3 cycles during a load-use hazard -> all stalls=1, flush_ex=0, state frozen. On release, exactly one load-use bubble follows.
6. Drive 2^CNT_W+1 flushes (CNT_W=4 in the test) -> flush_cnt stays 4'hF. rst_i mid-stall -> all outputs 0 and counters 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared stage-shadow types and forwarding-select encodings for the hazard controller
package hazard_ctrl_pkg;
   localparam int RAW = 5;
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   typedef struct packed {
      logic           valid;
      logic [RAW-1:0] rd;
      logic           wren;
      logic           is_load;
   } stage_info_t;
   typedef struct packed {
      stage_info_t    s;
      logic [RAW-1:0] rs1;
      logic           rs1_used;
      logic [RAW-1:0] rs2;
      logic           rs2_used;
   } ex_info_t;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_ctrl_fwd_sel: per-operand forwarding select, MEM wins over WB, x0 never forwarded
module hazard_ctrl_fwd_sel
   import hazard_ctrl_pkg::*;
(
   input  logic [RAW-1:0] rs,
   input  logic           used,
   input  stage_info_t    mem_q,
   input  stage_info_t    wb_q,
   output logic [1:0]     sel
);
   logic unused_ok;
   assign unused_ok = mem_q.is_load ^ wb_q.is_load;
   always_comb
      sel = (!used || rs == '0) ? FWD_REG :
            (mem_q.valid && mem_q.wren && mem_q.rd == rs) ? FWD_MEM :
            (wb_q.valid && wb_q.wren && wb_q.rd == rs) ? FWD_WB : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage core with saturating event counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = RAW,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_rd_wren_i,
   input  logic              id_is_load_i,
   input  logic              ex_redirect_i,
   input  logic              mem_stall_i,
   output logic              stall_if_o,
   output logic              stall_id_o,
   output logic              stall_ex_o,
   output logic              stall_mem_o,
   output logic              flush_id_o,
   output logic              flush_ex_o,
   output logic [1:0]        fwd_a_sel_o,
   output logic [1:0]        fwd_b_sel_o,
   output logic [CNT_W-1:0]  loaduse_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);
   ex_info_t    ex_q, ex_d;
   stage_info_t mem_q, wb_q;
   logic        redir_pend_q, redir, hz, lu;
   always_comb begin
      redir = !mem_stall_i && (ex_redirect_i || redir_pend_q);
      hz    = id_valid_i && ex_q.s.valid && ex_q.s.is_load && ex_q.s.rd != '0 &&
              ((id_rs1_used_i && id_rs1_i == ex_q.s.rd) || (id_rs2_used_i && id_rs2_i == ex_q.s.rd));
      lu    = !mem_stall_i && !redir && hz;
      ex_d  = (redir || lu) ? '0 : {id_valid_i, id_rd_i, id_rd_wren_i, id_is_load_i,
                                    id_rs1_i, id_rs1_used_i, id_rs2_i, id_rs2_used_i};
   end
   assign stall_if_o  = mem_stall_i || lu;
   assign stall_id_o  = mem_stall_i || lu;
   assign stall_ex_o  = mem_stall_i;
   assign stall_mem_o = mem_stall_i;
   assign flush_id_o  = redir;
   assign flush_ex_o  = redir || lu;
   hazard_ctrl_fwd_sel u_fwd_a (
      .rs(ex_q.rs1), .used(ex_q.s.valid && ex_q.rs1_used), .mem_q(mem_q), .wb_q(wb_q), .sel(fwd_a_sel_o)
   );
   hazard_ctrl_fwd_sel u_fwd_b (
      .rs(ex_q.rs2), .used(ex_q.s.valid && ex_q.rs2_used), .mem_q(mem_q), .wb_q(wb_q), .sel(fwd_b_sel_o)
   );
   // a redirect seen while frozen is remembered and taken once the freeze lifts
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         redir_pend_q  <= 1'b0;
         loaduse_cnt_o <= '0;
         flush_cnt_o   <= '0;
      end else if (mem_stall_i) begin
         redir_pend_q  <= redir_pend_q || ex_redirect_i;
      end else begin
         ex_q          <= ex_d;
         mem_q         <= ex_q.s;
         wb_q          <= mem_q;
         redir_pend_q  <= 1'b0;
         flush_cnt_o   <= flush_cnt_o + CNT_W'(redir && !(&flush_cnt_o));
         loaduse_cnt_o <= loaduse_cnt_o + CNT_W'(lu && !(&loaduse_cnt_o));
      end
   end
   a_no_mem_load_fwd: assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_q.valid && mem_q.is_load && ex_q.s.valid &&
        ((ex_q.rs1_used && ex_q.rs1 != '0 && ex_q.rs1 == mem_q.rd) ||
         (ex_q.rs2_used && ex_q.rs2 != '0 && ex_q.rs2 == mem_q.rd))));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plan scenarios plus randomized run against an instruction-level pipeline model
module tb_hazard_ctrl;
   localparam int CW  = 4;
   localparam int MAXC = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst, id_valid_i, id_rs1_used_i, id_rs2_used_i, id_rd_wren_i, id_is_load_i, ex_redirect_i, mem_stall_i;
   logic [4:0] id_rs1_i, id_rs2_i, id_rd_i;
   logic stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o;
   logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
   logic [CW-1:0] loaduse_cnt_o, flush_cnt_o;
   logic [9:0] obs;
   int total = 0, bad = 0;
   typedef struct { bit v; int rd; bit wr; bit ld; int rs1; bit u1; int rs2; bit u2; } ins_t;
   ins_t m_st [0:2];
   int m_lu, m_fl;
   bit m_pend;
   hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i),
      .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i), .ex_redirect_i(ex_redirect_i),
      .mem_stall_i(mem_stall_i), .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
      .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o), .flush_id_o(flush_id_o),
      .flush_ex_o(flush_ex_o), .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
      .loaduse_cnt_o(loaduse_cnt_o), .flush_cnt_o(flush_cnt_o)
   );
   always #5 clk = ~clk;
   assign obs = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o, flush_ex_o, fwd_a_sel_o, fwd_b_sel_o};

   function automatic ins_t cur_id();
      ins_t r;
      r.v = id_valid_i; r.rd = int'(id_rd_i); r.wr = id_rd_wren_i; r.ld = id_is_load_i;
      r.rs1 = int'(id_rs1_i); r.u1 = id_rs1_used_i; r.rs2 = int'(id_rs2_i); r.u2 = id_rs2_used_i;
      return r;
   endfunction
   function automatic bit m_hazard();
      ins_t p = m_st[0], c = cur_id();
      return c.v && p.v && p.ld && p.rd != 0 && ((c.u1 && c.rs1 == p.rd) || (c.u2 && c.rs2 == p.rd));
   endfunction
   // youngest older producer wins; its distance from EX is the select code
   function automatic logic [1:0] m_fwd(int rs, bit used);
      if (!m_st[0].v || !used || rs == 0) return 2'd0;
      for (int k = 1; k <= 2; k++)
         if (m_st[k].v && m_st[k].wr && m_st[k].rd == rs) return 2'(k);
      return 2'd0;
   endfunction
   function automatic logic [9:0] m_out();
      bit f = mem_stall_i;
      bit r = !f && (ex_redirect_i || m_pend);
      bit l = !f && !r && m_hazard();
      return {f | l, f | l, f, f, r, r | l, m_fwd(m_st[0].rs1, m_st[0].u1), m_fwd(m_st[0].rs2, m_st[0].u2)};
   endfunction
   task automatic mdl_step();
      bit r, l;
      r = !mem_stall_i && (ex_redirect_i || m_pend);
      l = !mem_stall_i && !r && m_hazard();
      if (rst) begin
         foreach (m_st[k]) m_st[k] = '{default: 0};
         m_lu = 0; m_fl = 0; m_pend = 0;
      end else if (mem_stall_i) begin
         m_pend = m_pend || ex_redirect_i;
      end else begin
         m_st[2] = m_st[1];
         m_st[1] = m_st[0];
         if (r || l) m_st[0] = '{default: 0};
         else m_st[0] = cur_id();
         if (r && m_fl < MAXC) m_fl++;
         if (l && m_lu < MAXC) m_lu++;
         m_pend = 0;
      end
   endtask
   task automatic tick();
      mdl_step();
      @(negedge clk);
   endtask
   task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld);
      id_valid_i = v; id_rs1_i = 5'(rs1); id_rs1_used_i = u1; id_rs2_i = 5'(rs2); id_rs2_used_i = u2;
      id_rd_i = 5'(rd); id_rd_wren_i = wr; id_is_load_i = ld;
   endtask
   task automatic idle();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      ex_redirect_i = 0; mem_stall_i = 0;
   endtask
   task automatic do_reset();
      rst = 1; idle(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset(); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL reset_outs: got %b want %b", obs, 10'b0); end
      total++; if (loaduse_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_lu_cnt: got %0d want 0", loaduse_cnt_o); end
      total++; if (flush_cnt_o !== 4'd0) begin bad++; $display("FAIL reset_fl_cnt: got %0d want 0", flush_cnt_o); end
   endtask
   task automatic test_loaduse();
      do_reset(); set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0); #1;
      total++; if (obs !== 10'b1100010000) begin bad++; $display("FAIL lu_stall: got %b want %b", obs, 10'b1100010000); end
      tick(); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL lu_one_bubble: got %b want %b", obs, 10'b0); end
      total++; if (loaduse_cnt_o !== 4'd1) begin bad++; $display("FAIL lu_cnt: got %0d want 1", loaduse_cnt_o); end
      tick(); idle(); #1;
      total++; if (obs !== 10'b0000001000) begin bad++; $display("FAIL lu_fwd_wb: got %b want %b", obs, 10'b0000001000); end
   endtask
   task automatic test_forward();
      do_reset(); set_id(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_id(1, 3, 1, 3, 1, 7, 1, 0); tick(); idle(); #1;
      total++; if (obs !== 10'b0000000101) begin bad++; $display("FAIL fwd_mem: got %b want %b", obs, 10'b0000000101); end
      do_reset(); set_id(1, 0, 0, 0, 0, 3, 1, 0); tick(); tick();
      set_id(1, 3, 1, 3, 1, 7, 1, 0); tick(); idle(); #1;
      total++; if (obs !== 10'b0000000101) begin bad++; $display("FAIL fwd_mem_over_wb: got %b want %b", obs, 10'b0000000101); end
      do_reset(); set_id(1, 0, 0, 0, 0, 3, 1, 0); tick();
      set_id(1, 0, 0, 0, 0, 9, 1, 0); tick();
      set_id(1, 3, 1, 3, 1, 7, 1, 0); tick(); idle(); #1;
      total++; if (obs !== 10'b0000001010) begin bad++; $display("FAIL fwd_wb: got %b want %b", obs, 10'b0000001010); end
   endtask
   task automatic test_x0();
      do_reset(); set_id(1, 0, 0, 0, 0, 0, 1, 0); tick();
      set_id(1, 0, 1, 0, 1, 7, 1, 0); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL x0_nostall: got %b want %b", obs, 10'b0); end
      tick(); set_id(1, 0, 0, 0, 0, 0, 1, 1); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL x0_nofwd: got %b want %b", obs, 10'b0); end
      tick(); set_id(1, 0, 1, 0, 1, 8, 1, 0); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL x0_load_nostall: got %b want %b", obs, 10'b0); end
      tick(); idle(); #1;
      total++; if (loaduse_cnt_o !== 4'd0) begin bad++; $display("FAIL x0_lu_cnt: got %0d want 0", loaduse_cnt_o); end
   endtask
   task automatic test_redirect_lu();
      do_reset(); set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0); ex_redirect_i = 1; #1;
      total++; if (obs !== 10'b0000110000) begin bad++; $display("FAIL redir_over_lu: got %b want %b", obs, 10'b0000110000); end
      tick(); idle(); #1;
      total++; if (flush_cnt_o !== 4'd1) begin bad++; $display("FAIL redir_fl_cnt: got %0d want 1", flush_cnt_o); end
      total++; if (loaduse_cnt_o !== 4'd0) begin bad++; $display("FAIL redir_lu_cnt: got %0d want 0", loaduse_cnt_o); end
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL redir_after: got %b want %b", obs, 10'b0); end
   endtask
   task automatic test_freeze();
      do_reset(); set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0); mem_stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (obs !== 10'b1111000000) begin bad++; $display("FAIL frz_hold%0d: got %b want %b", i, obs, 10'b1111000000); end
         tick();
      end
      mem_stall_i = 0; #1;
      total++; if (obs !== 10'b1100010000) begin bad++; $display("FAIL frz_release_lu: got %b want %b", obs, 10'b1100010000); end
      total++; if (loaduse_cnt_o !== 4'd0) begin bad++; $display("FAIL frz_lu_cnt_held: got %0d want 0", loaduse_cnt_o); end
      tick(); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL frz_single_bubble: got %b want %b", obs, 10'b0); end
      total++; if (loaduse_cnt_o !== 4'd1) begin bad++; $display("FAIL frz_lu_cnt: got %0d want 1", loaduse_cnt_o); end
      tick(); idle(); #1;
      total++; if (obs !== 10'b0000001000) begin bad++; $display("FAIL frz_fwd_wb: got %b want %b", obs, 10'b0000001000); end
      do_reset(); mem_stall_i = 1; ex_redirect_i = 1; #1;
      total++; if (obs !== 10'b1111000000) begin bad++; $display("FAIL frz_redir_held: got %b want %b", obs, 10'b1111000000); end
      tick(); mem_stall_i = 0; ex_redirect_i = 0; #1;
      total++; if (obs !== 10'b0000110000) begin bad++; $display("FAIL frz_redir_late: got %b want %b", obs, 10'b0000110000); end
      tick(); #1;
      total++; if (flush_cnt_o !== 4'd1 || obs !== 10'b0) begin bad++; $display("FAIL frz_redir_once: got cnt=%0d outs=%b want cnt=1 outs=0", flush_cnt_o, obs); end
   endtask
   task automatic test_sat_and_reset();
      do_reset(); ex_redirect_i = 1;
      for (int i = 1; i <= (1 << CW) + 1; i++) begin
         tick(); #1;
         total++; if (flush_cnt_o !== 4'(i > MAXC ? MAXC : i)) begin bad++; $display("FAIL sat_fl_cnt%0d: got %0d want %0d", i, flush_cnt_o, (i > MAXC ? MAXC : i)); end
      end
      ex_redirect_i = 0; set_id(1, 0, 0, 0, 0, 5, 1, 1); tick();
      set_id(1, 5, 1, 1, 1, 6, 1, 0); mem_stall_i = 1; tick();
      rst = 1; tick(); rst = 0; idle(); #1;
      total++; if (obs !== 10'b0 || flush_cnt_o !== 4'd0 || loaduse_cnt_o !== 4'd0) begin bad++; $display("FAIL rst_mid_stall: got outs=%b fl=%0d lu=%0d want all 0", obs, flush_cnt_o, loaduse_cnt_o); end
      set_id(1, 5, 1, 1, 1, 6, 1, 0); #1;
      total++; if (obs !== 10'b0) begin bad++; $display("FAIL rst_shadow_clear: got %b want %b", obs, 10'b0); end
      tick();
   endtask
   task automatic test_random();
      logic [9:0] e;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 39) == 0);
         mem_stall_i = ($urandom_range(0, 5) == 0);
         ex_redirect_i = ($urandom_range(0, 6) == 0);
         set_id($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
                $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
         #1; e = m_out();
         total++; if (obs !== e) begin bad++; $display("FAIL rnd_outs@%0d: got %b want %b", c, obs, e); end
         total++; if (loaduse_cnt_o !== 4'(m_lu) || flush_cnt_o !== 4'(m_fl)) begin bad++; $display("FAIL rnd_cnts@%0d: got lu=%0d fl=%0d want lu=%0d fl=%0d", c, loaduse_cnt_o, flush_cnt_o, m_lu, m_fl); end
         tick();
      end
      rst = 0;
   endtask

   initial begin
      rst = 1; idle();
      test_reset();
      test_loaduse();
      test_forward();
      test_x0();
      test_redirect_lu();
      test_freeze();
      test_sat_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
